// File: rtl/mbus_timer_pkg.sv
// Shared definitions for the mbus timer: register offsets and CTRL/STAT bit positions.
package mbus_timer_pkg;

  typedef enum logic [3:0] {
    TMR_CNT  = 4'd0,
    TMR_RLD  = 4'd1,
    TMR_CTRL = 4'd2,
    TMR_STAT = 4'd3,
    TMR_PRE  = 4'd4,
    TMR_CMP  = 4'd5
  } tmr_reg_e;

  localparam int unsigned RUNIDX = 0;
  localparam int unsigned ARIDX  = 1;
  localparam int unsigned IEIDX  = 2;

  localparam int unsigned OVFIDX = 0;
  localparam int unsigned CMFIDX = 1;

  localparam int unsigned CTRL_BITS = 3;
  localparam int unsigned STAT_BITS = 2;

endpackage

// File: rtl/mbus_timer_if.sv
// CPU memory-bus responder port: decoder select, address, write data/strobe, read data.
interface mbus_timer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cs;
  logic [3:0]       addr;
  logic [WIDTH-1:0] din;
  logic             wen;
  logic [WIDTH-1:0] dout;

  modport master (output cs, addr, din, wen, input dout);
  modport slave  (input cs, addr, din, wen, output dout);
endinterface

// File: rtl/mbus_timer_presc.sv
// Prescaler: emits one tick every pre+1 enabled cycles; clr restarts the count.
module timer_presc #(
  parameter int unsigned PRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [PRE_WIDTH-1:0] pre,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] pcnt;

  assign tick = en & (pcnt == pre);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (clr || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + PRE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mbus_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload, compare match and irq.
module mbus_timer
  import mbus_timer_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PRE_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  mbus_timer_if.slave   bus,
  output logic          irq
);

  logic [WIDTH-1:0]     cnt;
  logic [WIDTH-1:0]     rld;
  logic [WIDTH-1:0]     cmp;
  logic [PRE_WIDTH-1:0] pre;
  logic [CTRL_BITS-1:0] ctrl;
  logic [STAT_BITS-1:0] stat;

  logic we;
  logic wr_cnt, wr_rld, wr_ctrl, wr_stat, wr_pre, wr_cmp;
  logic tick;
  logic ovf_set, cmf_set;
  logic [STAT_BITS-1:0] stat_set, stat_clr;

  assign we      = bus.cs & bus.wen;
  assign wr_cnt  = we & (bus.addr == TMR_CNT);
  assign wr_rld  = we & (bus.addr == TMR_RLD);
  assign wr_ctrl = we & (bus.addr == TMR_CTRL);
  assign wr_stat = we & (bus.addr == TMR_STAT);
  assign wr_pre  = we & (bus.addr == TMR_PRE);
  assign wr_cmp  = we & (bus.addr == TMR_CMP);

  timer_presc #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl[RUNIDX]),
    .clr   (wr_ctrl | wr_pre),
    .pre   (pre),
    .tick  (tick)
  );

  // Both flags judge the pre-update count, so they still fire when a bus write to CNT wins.
  assign ovf_set = tick & (cnt == '0);
  assign cmf_set = tick & (cnt == cmp);

  always_comb begin
    stat_set         = '0;
    stat_set[OVFIDX] = ovf_set;
    stat_set[CMFIDX] = cmf_set;
  end

  assign stat_clr = wr_stat ? bus.din[STAT_BITS-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      rld  <= '0;
      cmp  <= '0;
      pre  <= '0;
      ctrl <= '0;
      stat <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_cnt) begin
        cnt <= bus.din;
      end else if (tick) begin
        if (cnt == '0) begin
          if (ctrl[ARIDX]) cnt <= rld;
        end else begin
          cnt <= cnt - WIDTH'(1);
        end
      end

      if (wr_rld) rld <= bus.din;
      if (wr_cmp) cmp <= bus.din;
      if (wr_pre) pre <= bus.din[PRE_WIDTH-1:0];

      // A CTRL write overrides the one-shot stop landing in the same cycle.
      if (wr_ctrl) begin
        ctrl <= bus.din[CTRL_BITS-1:0];
      end else if (ovf_set && !ctrl[ARIDX]) begin
        ctrl[RUNIDX] <= 1'b0;
      end

      stat <= (stat & ~stat_clr) | stat_set;
      irq  <= ctrl[IEIDX] & (stat[OVFIDX] | stat[CMFIDX]);
    end
  end

  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      TMR_CNT:  bus.dout = cnt;
      TMR_RLD:  bus.dout = rld;
      TMR_CTRL: bus.dout[CTRL_BITS-1:0] = ctrl;
      TMR_STAT: bus.dout[STAT_BITS-1:0] = stat;
      TMR_PRE:  bus.dout[PRE_WIDTH-1:0] = pre;
      TMR_CMP:  bus.dout = cmp;
      default:  bus.dout = '0;
    endcase
  end

endmodule

// File: doc/mbus_timer.md
Name: mbus_timer

Overview:
- Memory-mapped down-counting timer; a responder on the CPU memory bus (mbus).
- Sits behind the system address decoder, which drives cs.
- Consumes the CPU's address, write-data and write-enable; returns read data.
- Provides a programmable prescaler, auto-reload, compare match, sticky status flags and a level interrupt request.

Parameters:
- WIDTH, 32, bus data width and width of the CNT/RLD/CMP registers.
- PRE_WIDTH, 16, width of the PRE register and the prescaler counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  chip select from the address decoder.
- addr  input  4  register offset, driven from mbus_aout[3:0].
- din  input  WIDTH  write data, driven from mbus_dout.
- wen  input  1  write strobe, driven from mbus_wen.
- dout  output  WIDTH  read data, to the CPU mbus_din mux.
- irq  output  1  interrupt request, level, active-high.

Behaviour:
- Register map:
  - 0 CNT: counter.
  - 1 RLD: reload value.
  - 2 CTRL: bit0 RUN, bit1 AR (auto-reload), bit2 IE; other bits read 0.
  - 3 STAT: bit0 OVF, bit1 CMF; write-1-to-clear.
  - 4 PRE: zero-extended on read.
  - 5 CMP: compare value.
  - Offsets 6..15 read 0; writes to them are ignored.
- Read path:
  - dout is combinational from addr and current register state, independent of cs; the decoder muxes it.
  - Zero wait states. The CPU samples in its MEM phase, so there is no read latency and no read side effects.
- Write path:
  - A write takes effect at the posedge where cs & wen = 1.
  - The new value is visible on dout from the next cycle.
- Reset: all registers, the prescaler count, irq and dout contents are 0. Mid-operation reset aborts counting, with no partial state.
- Prescaler:
  - pcnt counts while RUN=1; it holds when RUN=0.
  - tick = RUN & (pcnt==PRE). On tick, pcnt<=0; otherwise pcnt<=pcnt+1.
  - Result: one tick every PRE+1 cycles; PRE=0 gives a tick every cycle.
  - Any write to CTRL or PRE clears pcnt.
- Counter, on tick:
  - If CNT==CMP, set CMF, using the pre-update value.
  - If CNT==0: set OVF. If AR=1, CNT<=RLD; else CNT stays 0 and RUN<=0 (one-shot stop).
  - Otherwise CNT<=CNT-1. Arithmetic is unsigned WIDTH-bit; no wrap below 0.
- Simultaneous events:
  - A bus write to CNT in the same cycle as a tick: the write wins and the tick's CNT update is dropped. Flag setting from that tick still occurs.
  - A bus write to CTRL clearing RUN in the same cycle as a one-shot stop: result is RUN=0.
  - A STAT write-1-to-clear in the same cycle as a flag set: the set wins, so the flag remains 1.
  - RLD=0 with AR=1: OVF is set on every tick.
- Interrupt: irq = IE & (OVF | CMF), registered, so it asserts the cycle after the flag is set.

Decomposition:
- Shared defines header, alongside the existing flag-index defines:
  - register offsets (TMR_CNT..TMR_CMP);
  - CTRL bit indices (RUNIDX, ARIDX, IEIDX);
  - STAT bit indices (OVFIDX, CMFIDX).
- One sub-module, timer_presc:
  - inputs: clk, reset, en, clr, pre;
  - output: tick.
  - Holds pcnt and the compare-to-PRE logic.
- Register file and counter logic stay in mbus_timer.

Test Plan:
1. Reset, then read offsets 0..15 -> dout=0 for every offset; irq=0.
2. Write PRE=1, RLD=3, CNT=3, CTRL=0x3 -> CNT reads 2,1,0 after ticks 1..3 (one tick every 2 cycles); OVF=1 and CNT=3 at the 8th posedge after the CTRL write.
3. One-shot with PRE=0, CNT=2, CTRL=0x1 -> CNT 1,0 over 2 cycles; cycle 3 sets OVF, RUN reads 0 and CNT holds 0 thereafter.
4. CMP=5, CNT=7, PRE=0, CTRL=0x5 (RUN+IE) -> CMF set on the 3rd tick; irq=1 the following cycle; write STAT=0x2 -> CMF=0 and irq=0 the cycle after; OVF unaffected.
5. Write CNT=0x100 in the same cycle as a tick (PRE=0, RUN=1) -> CNT reads 0x100 next cycle, not 0xFF; a concurrent STAT clear of a flag being set leaves the flag at 1.
6. Write with cs=0 and wen=1 to every offset -> no register changes; assert reset mid-count -> all registers 0 on the next cycle and irq=0.
